sample_ring_buffer: RTL and testbench

Circular sample buffer that sits between the I2S receiver and the VU meter. It takes one channel of 24-bit signed audio samples from a push-only write port and stores them in a synchronous-read dual-port RAM. Stored samples are presented on a valid/ready read port that matches the meter's `ram_read_*` inputs. It also raises a fill-level flag that drives the meter's `ram_buffer_ready_i`.

---
 rtl/fpga_template_pkg.sv | 14 +
 rtl/sample_ring_ram.sv | 28 ++
 rtl/sample_ring_buffer.sv | 151 +++++++++++++++
 tb/tb_sample_ring_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_template_pkg.sv
// Types shared between the sample ring buffer and the VU meter.
package fpga_template_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    RB_IDLE    = 2'd0,
    RB_FETCH   = 2'd1,
    RB_PRESENT = 2'd2
  } rb_state_e;

endpackage

// File: rtl/sample_ring_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module sample_ring_ram
  import fpga_template_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  sample_t       wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output sample_t       rd_data_o
);

  sample_t mem_q [DEPTH];
  sample_t rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_ring_buffer.sv
// Circular buffer of one I2S channel feeding the VU meter's valid/ready read port.
// Define SAMPLE_RING_BUFFER_OVF_COUNT_EN to add the saturating overflow_count_o port.
//
// state      | meaning
// RB_IDLE    | wait for a stored sample, issue RAM read at rd_ptr_q
// RB_FETCH   | capture RAM output into rd_data_q, raise rd_valid_o
// RB_PRESENT | hold sample stable until rd_valid_o && rd_ready_i
module sample_ring_buffer
  import fpga_template_pkg::*;
#(
  parameter int   DEPTH        = 256,
  parameter int   READY_THRESH = 64,
  parameter logic SELECT_LEFT  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  sample_t                wr_data_i,
  input  logic                   wr_valid_i,
  input  logic                   wr_left_i,
  output sample_t                rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic                   buffer_ready_o,
  output logic [$clog2(DEPTH):0] fill_level_o,
  output logic                   overflow_o
`ifdef SAMPLE_RING_BUFFER_OVF_COUNT_EN
  ,
  output logic [15:0]            overflow_count_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(READY_THRESH);

  rb_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  sample_t       rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          buffer_ready_q, buffer_ready_d;
  logic          overflow_q, overflow_d;

  logic    wr_accept, full, wr_en, wr_drop, rd_en, rd_hs;
  sample_t ram_rdata;

  sample_ring_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  // Full is judged on the registered count, so a write racing a handshake at full is dropped.
  always_comb begin
    wr_accept = wr_valid_i && (wr_left_i == SELECT_LEFT);
    full      = (count_q == DEPTH_C);
    wr_en     = wr_accept && !full;
    wr_drop   = wr_accept && full;
    rd_en     = (state_q == RB_IDLE) && (count_q != '0);
    rd_hs     = (state_q == RB_PRESENT) && rd_valid_q && rd_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_ptr_d   = rd_ptr_q;
    unique case (state_q)
      RB_IDLE: begin
        if (count_q != '0) state_d = RB_FETCH;
      end
      RB_FETCH: begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = RB_PRESENT;
      end
      RB_PRESENT: begin
        if (rd_hs) begin
          rd_valid_d = 1'b0;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          state_d    = RB_IDLE;
        end
      end
      default: state_d = RB_IDLE;
    endcase
  end

  // The presented sample stays counted until its handshake, protecting its RAM slot.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_hs)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_hs) count_d = count_q - CW'(1);
    buffer_ready_d = (count_d >= THRESH_C);
    overflow_d     = overflow_q | wr_drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= RB_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      buffer_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      buffer_ready_q <= buffer_ready_d;
      overflow_q     <= overflow_d;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign buffer_ready_o = buffer_ready_q;
  assign fill_level_o   = count_q;
  assign overflow_o     = overflow_q;

`ifdef SAMPLE_RING_BUFFER_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (wr_drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_cnt_q <= '0;
    else         ovf_cnt_q <= ovf_cnt_d;
  end

  assign overflow_count_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Directed self-checking bench for sample_ring_buffer (DEPTH=256, READY_THRESH=64, left channel).
module tb_sample_ring_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [23:0] wr_data_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_left_i = 1'b0;
  logic [23:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic        buffer_ready_o;
  logic [8:0]  fill_level_o;
  logic        overflow_o;
`ifdef SAMPLE_RING_BUFFER_OVF_COUNT_EN
  logic [15:0] overflow_count_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  sample_ring_buffer #(
    .DEPTH        (256),
    .READY_THRESH (64),
    .SELECT_LEFT  (1'b1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_data_i      (wr_data_i),
    .wr_valid_i     (wr_valid_i),
    .wr_left_i      (wr_left_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .buffer_ready_o (buffer_ready_o),
    .fill_level_o   (fill_level_o),
    .overflow_o     (overflow_o)
`ifdef SAMPLE_RING_BUFFER_OVF_COUNT_EN
    ,
    .overflow_count_o (overflow_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    #3;
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_fill", 32'(fill_level_o), 32'd0);
    chk("rst_bufrdy", 32'(buffer_ready_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_data", 32'(rd_data_o), 32'd0);
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic write(input logic [23:0] d, input logic left);
    wr_data_i  = d;
    wr_left_i  = left;
    wr_valid_i = 1'b1;
    step();
    wr_valid_i = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [23:0] exp);
    int n = 0;
    while (!rd_valid_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    chk(tag, 32'(rd_data_o), 32'(exp));
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
  endtask

  initial begin
    int got;
    int wr_idx;
    do_reset();

    // Single sample latency and handshake
    rd_ready_i = 1'b1;
    write(24'h123456, 1'b1);
    chk("t1_fill_after_wr", 32'(fill_level_o), 32'd1);
    chk("t1_valid_c1", 32'(rd_valid_o), 32'd0);
    step();
    chk("t1_valid_c2", 32'(rd_valid_o), 32'd0);
    step();
    chk("t1_valid_c3", 32'(rd_valid_o), 32'd1);
    chk("t1_data", 32'(rd_data_o), 32'h123456);
    chk("t1_fill_present", 32'(fill_level_o), 32'd1);
    step();
    chk("t1_valid_after_hs", 32'(rd_valid_o), 32'd0);
    chk("t1_fill_after_hs", 32'(fill_level_o), 32'd0);
    rd_ready_i = 1'b0;

    // Channel filter: only left samples stored
    for (int i = 0; i < 10; i++) begin
      write(24'hF00000 + 24'(i), 1'b0);
      write(24'h000100 + 24'(i), 1'b1);
    end
    chk("t2_fill_peak", 32'(fill_level_o), 32'd10);
    for (int i = 0; i < 10; i++) pop("t2_data", 24'h000100 + 24'(i));
    step();
    chk("t2_fill_drained", 32'(fill_level_o), 32'd0);
    chk("t2_valid_drained", 32'(rd_valid_o), 32'd0);

    // Ready threshold
    do_reset();
    for (int i = 0; i < 63; i++) write(24'(i), 1'b1);
    chk("t3_fill_63", 32'(fill_level_o), 32'd63);
    chk("t3_bufrdy_63", 32'(buffer_ready_o), 32'd0);
    write(24'd63, 1'b1);
    chk("t3_fill_64", 32'(fill_level_o), 32'd64);
    chk("t3_bufrdy_64", 32'(buffer_ready_o), 32'd1);

    // Overflow: 260 writes into 256 slots
    do_reset();
    for (int i = 0; i < 256; i++) write(24'(i), 1'b1);
    chk("t4_fill_full", 32'(fill_level_o), 32'd256);
    chk("t4_ovf_at_full", 32'(overflow_o), 32'd0);
    for (int i = 256; i < 260; i++) write(24'(i), 1'b1);
    chk("t4_fill_after_drop", 32'(fill_level_o), 32'd256);
    chk("t4_ovf", 32'(overflow_o), 32'd1);
`ifdef SAMPLE_RING_BUFFER_OVF_COUNT_EN
    chk("t4_ovf_count", 32'(overflow_count_o), 32'd4);
`endif
    for (int i = 0; i < 256; i++) pop("t4_data", 24'(i));
    step();
    chk("t4_fill_drained", 32'(fill_level_o), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow_o), 32'd1);

    // Reset in PRESENT with five samples stored
    for (int i = 0; i < 5; i++) write(24'h500 + 24'(i), 1'b1);
    step();
    step();
    chk("t6_valid_pre", 32'(rd_valid_o), 32'd1);
    chk("t6_fill_pre", 32'(fill_level_o), 32'd5);
    rst_ni = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(rd_valid_o), 32'd0);
    chk("t6_fill_rst", 32'(fill_level_o), 32'd0);
    chk("t6_bufrdy_rst", 32'(buffer_ready_o), 32'd0);
    chk("t6_ovf_rst", 32'(overflow_o), 32'd0);
    #1;
    rst_ni = 1'b1;
    step();
    write(24'hABCDEF, 1'b1);
    chk("t6_valid_c1", 32'(rd_valid_o), 32'd0);
    step();
    chk("t6_valid_c2", 32'(rd_valid_o), 32'd0);
    step();
    chk("t6_valid_c3", 32'(rd_valid_o), 32'd1);
    chk("t6_data", 32'(rd_data_o), 32'hABCDEF);

    // Wrap-around streaming: producer every 4th cycle, consumer ready every 3rd
    do_reset();
    got = 0;
    wr_idx = 0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      wr_valid_i = (c % 4 == 0) && (wr_idx < 1000);
      wr_left_i  = 1'b1;
      wr_data_i  = 24'(wr_idx);
      if (wr_valid_i) wr_idx++;
      rd_ready_i = (c % 3 == 0);
      if (rd_valid_o && rd_ready_i) begin
        chk("t5_stream", 32'(rd_data_o), 32'(got));
        got++;
      end
      step();
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    chk("t5_count", 32'(got), 32'd1000);
    chk("t5_ovf", 32'(overflow_o), 32'd0);
    step();
    chk("t5_fill_end", 32'(fill_level_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
